// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scan controller for a DIGITS-wide 7-segment display: blanking gap per slot, frame-boundary double buffering.
// Optional leading-zero blanking is enabled by defining SEVEN_SEGMENT_SCANNER_LZB_EN.
module seven_segment_scanner #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic [3:0]            nibble,
    input  logic [6:0]            segs_in,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an_out,
    output logic                  frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d, idx_next;
    logic [3:0]          nibble_q, nibble_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_done_q, frame_done_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d, pend_q, pend_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d, pend_dp_q, pend_dp_d;
    logic                pend_vld_q, pend_vld_d;
    logic                slot_end, last_digit, boundary;
    logic [DIGITS-1:0]   lit, an_sel;
    logic                cur_dp;

`ifdef SEVEN_SEGMENT_SCANNER_LZB_EN
    logic above;

    // A digit is lit if it or any more significant digit carries a non-zero nibble or a dp.
    always_comb begin
        lit   = '0;
        above = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            above  = above | (|shadow_q[4*i +: 4]) | shadow_dp_q[i];
            lit[i] = above || (i == 0);
        end
    end
`else
    assign lit = '1;
`endif

    always_comb begin
        slot_end   = (cnt_q == CW'(PRESCALE - 1));
        last_digit = (idx_q == IW'(DIGITS - 1));
        boundary   = (state_q == ST_SHOW) && slot_end && last_digit;
        cnt_d      = slot_end ? '0 : cnt_q + CW'(1);
        idx_next   = last_digit ? '0 : idx_q + IW'(1);
        idx_d      = slot_end ? idx_next : idx_q;

        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_vld_d  = pend_vld_q;
        if (load && boundary) begin
            // A load landing exactly on the boundary goes straight to the shadow.
            shadow_d    = value;
            shadow_dp_d = dp_in;
            pend_vld_d  = 1'b0;
        end else begin
            if (boundary && pend_vld_q) begin
                shadow_d    = pend_q;
                shadow_dp_d = pend_dp_q;
            end
            if (load) begin
                pend_d     = value;
                pend_dp_d  = dp_in;
                pend_vld_d = 1'b1;
            end else if (boundary) begin
                pend_vld_d = 1'b0;
            end
        end

        an_sel = '0;
        cur_dp = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                an_sel[i] = 1'b1;
                cur_dp    = shadow_dp_q[i];
            end
        end

        state_d      = state_q;
        nibble_d     = nibble_q;
        seg_d        = seg_q;
        dp_d         = dp_q;
        an_d         = an_q;
        frame_done_d = boundary;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CW'(BLANK - 1)) begin
                    seg_d   = segs_in;
                    dp_d    = cur_dp;
                    an_d    = an_sel & lit;
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (slot_end) begin
                    seg_d    = '0;
                    dp_d     = 1'b0;
                    an_d     = '0;
                    state_d  = ST_BLANK;
                    // Uses the next shadow so a frame-boundary swap reaches digit 0 immediately.
                    nibble_d = '0;
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx_next == IW'(i)) nibble_d = shadow_d[4*i +: 4];
                    end
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            nibble_q     <= '0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            an_q         <= '0;
            frame_done_q <= 1'b0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            pend_q       <= '0;
            pend_dp_q    <= '0;
            pend_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            nibble_q     <= nibble_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_vld_q   <= pend_vld_d;
        end
    end

    assign nibble     = nibble_q;
    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner with DIGITS=4, PRESCALE=8, BLANK=2 and a slot/frame arithmetic model.
module tb_seven_segment_scanner;

    localparam int D = 4;
    localparam int P = 8;
    localparam int B = 2;
`ifdef SEVEN_SEGMENT_SCANNER_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic [3:0]  nibble;
    logic [6:0]  segs_in, seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int n_chk = 0;
    int n_pass = 0;

    int          m_t;
    logic [15:0] m_shadow, m_pend;
    logic [3:0]  m_sdp, m_pdp;
    logic        m_pv;

    int          last_fd = -1;
    bit          seen3 = 1'b0;
    int          c_cnt, c_idx;
    bit          c_lit;
    logic [3:0]  c_nib;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h3F; 4'h1: seg7 = 7'h06; 4'h2: seg7 = 7'h5B; 4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66; 4'h5: seg7 = 7'h6D; 4'h6: seg7 = 7'h7D; 4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F; 4'h9: seg7 = 7'h6F; 4'hA: seg7 = 7'h77; 4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39; 4'hD: seg7 = 7'h5E; 4'hE: seg7 = 7'h79; default: seg7 = 7'h71;
        endcase
    endfunction

    function automatic bit is_boundary(input int t);
        return (t % P == P - 1) && ((t / P) % D == D - 1);
    endfunction

    assign segs_in = seg7(nibble);

    always #5 clk = ~clk;

    seven_segment_scanner #(.DIGITS(D), .PRESCALE(P), .BLANK(B)) dut (
        .clk(clk), .reset(rst), .value(value), .dp_in(dp_in), .load(load),
        .nibble(nibble), .segs_in(segs_in), .seg_out(seg_out), .dp_out(dp_out),
        .an_out(an_out), .frame_done(frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, m_t);
    endtask

    // Model: m_t counts cycles since reset release; shadow/pending follow the buffering rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t <= 0; m_shadow <= '0; m_sdp <= '0; m_pend <= '0; m_pdp <= '0; m_pv <= 1'b0;
        end else begin
            if (load && is_boundary(m_t)) begin
                m_shadow <= value; m_sdp <= dp_in; m_pv <= 1'b0;
            end else begin
                if (is_boundary(m_t) && m_pv) begin
                    m_shadow <= m_pend; m_sdp <= m_pdp;
                end
                if (load) begin
                    m_pend <= value; m_pdp <= dp_in; m_pv <= 1'b1;
                end else if (is_boundary(m_t)) begin
                    m_pv <= 1'b0;
                end
            end
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_an", an_out, 0);
            check("rst_seg", seg_out, 0);
            check("rst_nib", nibble, 0);
            check("rst_fd", frame_done, 0);
            last_fd = -1;
        end else begin
            c_cnt = m_t % P;
            c_idx = (m_t / P) % D;
            c_nib = m_shadow[4*c_idx +: 4];
            c_lit = !LZB || (c_idx == 0) || ((m_shadow >> (4*c_idx)) != 0) || ((m_sdp >> c_idx) != 0);
            check("nibble", nibble, c_nib);
            check("an_out", an_out, (c_cnt >= B && c_lit) ? (32'd1 << c_idx) : 32'd0);
            check("seg_out", seg_out, (c_cnt >= B) ? seg7(c_nib) : 7'd0);
            check("dp_out", dp_out, (c_cnt >= B) ? m_sdp[c_idx] : 1'b0);
            check("frame_done", frame_done, (m_t > 0 && c_cnt == 0 && c_idx == 0));
            if (an_out != 0 && seg_out == 7'h4F) seen3 = 1'b1;
            if (frame_done) begin
                if (last_fd >= 0) check("fd_period", m_t - last_fd, 32);
                last_fd = m_t;
            end
        end
    end

    task automatic wait_t(input int target);
        int n = 0;
        while (m_t != target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (m_t != target) check("wait_timeout", m_t, target);
    endtask

    task automatic do_load(input int t, input logic [15:0] v, input logic [3:0] dp);
        wait_t(t);
        value = v; dp_in = dp; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pin(input string name, input int t, input logic [3:0] an, input logic [6:0] seg);
        wait_t(t);
        check({name, "_an"}, an_out, an);
        check({name, "_seg"}, seg_out, seg);
    endtask

    initial begin
        int n;
        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0;
        repeat (3) @(negedge clk);
        check("reset_dp", dp_out, 0);
        rst = 1'b0;

        do_load(1, 16'h12AF, 4'b0000);
        wait_t(32);
        check("f1_frame_done", frame_done, 1);
        check("f1_blank_an", an_out, 0);
        pin("f1_d0", 34, 4'b0001, 7'h71);
        check("f1_d0_nib", nibble, 4'hF);
        pin("f1_d1", 42, 4'b0010, 7'h77);
        pin("f1_d2", 50, 4'b0100, 7'h5B);
        pin("f1_d3", 58, 4'b1000, 7'h06);

        do_load(75, 16'h0003, 4'b0000);
        do_load(81, 16'h0004, 4'b0000);
        pin("f2_d3_old", 90, 4'b1000, 7'h06);
        pin("f3_d0_four", 98, 4'b0001, 7'h66);

        do_load(127, 16'h5555, 4'b0000);
        do_load(129, 16'h0070, 4'b0000);
        pin("f4_d0_bypass", 130, 4'b0001, 7'h6D);
        check("f4_d0_nib", nibble, 4'h5);

        do_load(161, 16'h0000, 4'b0100);
        pin("f5_d0", 162, 4'b0001, 7'h3F);
        pin("f5_d1", 170, 4'b0010, 7'h07);
        pin("f5_d2", 178, LZB ? 4'b0000 : 4'b0100, 7'h3F);
        pin("f5_d3", 186, LZB ? 4'b0000 : 4'b1000, 7'h3F);

        pin("f6_d2", 210, 4'b0100, 7'h3F);
        check("f6_d2_dp", dp_out, 1);
        pin("f6_d3", 218, LZB ? 4'b0000 : 4'b1000, 7'h3F);
        check("f6_d3_dp", dp_out, 0);
        pin("f7_d0", 226, 4'b0001, 7'h3F);
        pin("f7_d1", 234, 4'b0010, 7'h3F);

        pin("f7_d2_pre_reset", 244, 4'b0100, 7'h3F);
        #2 rst = 1'b1;
        #1;
        check("midreset_an", an_out, 0);
        check("midreset_seg", seg_out, 0);
        check("midreset_dp", dp_out, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (an_out == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("first_an_cycle", n, 2);
        check("first_an_val", an_out, 4'b0001);
        check("first_seg_zero", seg_out, 7'h3F);
        wait_t(40);

        check("three_never_shown", seen3, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
